// File: rtl/delta_pe_lanes.sv
// Multi-lane multiply / shift-accumulate processing element with a shared activation.
// Stage 1 registers one term per lane, stage 2 accumulates; results are held until taken.
module delta_pe_lanes #(
    parameter int unsigned BIN_LEN     = 8,
    parameter int unsigned DELTA_LEN   = 3,
    parameter int unsigned OUT_BIN_LEN = 24,
    parameter int unsigned LANES       = 4,
    parameter int unsigned SATURATE    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic                         in_last,
    input  logic [BIN_LEN-1:0]           input_val,
    input  logic [LANES*BIN_LEN-1:0]     weight_val,
    input  logic [LANES*DELTA_LEN-1:0]   delta_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*OUT_BIN_LEN-1:0] w_val,
    output logic [LANES-1:0]             ovf,
    output logic [15:0]                  beat_count
);

    localparam int unsigned PW = 2 * BIN_LEN;
    localparam int unsigned OW = OUT_BIN_LEN;
    localparam logic [OW-1:0] SatMax = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SatMin = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

    state_e      state_q;
    logic        term_v_q;
    logic        out_valid_q;
    logic [15:0] cnt_q;
    logic        accept;
    logic        clear_grp;

    assign in_ready   = enable & (state_q == StAccum);
    assign accept     = in_valid & in_ready;
    assign clear_grp  = (state_q == StHold) & out_ready;
    assign out_valid  = out_valid_q;
    assign beat_count = cnt_q;

    // DRAIN waits until stage 1 is empty, so the final term has been summed before HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StAccum;
            term_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= 16'd0;
        end else if (enable) begin
            term_v_q <= accept;
            case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                        if (in_last) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!term_v_q) begin
                        state_q     <= StHold;
                        out_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StAccum;
                        out_valid_q <= 1'b0;
                        cnt_q       <= 16'd0;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [PW-1:0] prod;
        logic        [OW-1:0] x_ext;
        logic        [OW-1:0] term_c;
        logic        [OW-1:0] term_q;
        logic        [OW-1:0] acc_q;
        logic        [OW-1:0] acc_next;
        logic        [OW:0]   sum;
        logic                 lane_ovf;
        logic                 ovf_q;

        assign prod   = $signed(input_val) * $signed(weight_val[i*BIN_LEN +: BIN_LEN]);
        assign x_ext  = OW'($signed(input_val));
        assign term_c = in_mode ? OW'(prod)
                                : (x_ext << delta_val[i*DELTA_LEN +: DELTA_LEN]);

        // One guard bit: signed overflow shows up as the top two bits disagreeing.
        assign sum      = {acc_q[OW-1], acc_q} + {term_q[OW-1], term_q};
        assign lane_ovf = sum[OW] ^ sum[OW-1];

        always_comb begin
            acc_next = sum[OW-1:0];
            if (lane_ovf && (SATURATE != 0)) acc_next = sum[OW] ? SatMin : SatMax;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                term_q <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else if (enable) begin
                if (accept) term_q <= term_c;
                if (clear_grp) begin
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end else if (term_v_q) begin
                    acc_q <= acc_next;
                    ovf_q <= ovf_q | lane_ovf;
                end
            end
        end

        assign w_val[i*OW +: OW] = acc_q;
        assign ovf[i]            = ovf_q;
    end

endmodule
